// File: rtl/pea_pkg.sv
// Shared widths and state type for the PE output path.
package pea_pkg;

    localparam int unsigned N_BITS = 32;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN_DONE
    } out_buf_state_t;

endpackage

// File: rtl/out_fifo.sv
// First-word-fall-through storage with wrapping pointers and occupancy count.
module out_fifo #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned N_BITS = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      flush_i,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  logic [N_BITS-1:0]         wdata_i,
    output logic [N_BITS-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      full_o,
    output logic                      empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [N_BITS-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;

    // Pointer and occupancy next-state; flush wins over push/pop.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) wptr_d = wptr_q + AW'(1);
            if (pop_i)  rptr_d = rptr_q + AW'(1);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Data storage is intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/pe_out_buffer.sv
// PE result output buffer: FWFT FIFO plus transfer framing, done pulse and overflow flag.
module pe_out_buffer
    import pea_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned LEN_BITS = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [N_BITS-1:0]       pe_res_i,
    input  logic                    stream_valid_i,
    input  logic                    flush_i,
    input  logic [LEN_BITS-1:0]     xfer_len_i,
    output logic [N_BITS-1:0]       out_data_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic                    out_last_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic                    overflow_o,
    output logic                    done_o
);

    out_buf_state_t      state_q, state_d;
    logic [LEN_BITS-1:0] pcnt_q, pcnt_d;
    logic                overflow_q, overflow_d;
    logic                done_q, done_d;
    logic                full_c, empty_c;
    logic                push_c, pop_c, drop_c, last_c;

    // Handshake qualification; a push into a full buffer is legal only alongside a pop.
    always_comb begin
        pop_c  = !empty_c && out_ready_i && !flush_i;
        push_c = stream_valid_i && (!full_c || pop_c) && !flush_i;
        drop_c = stream_valid_i && full_c && !pop_c && !flush_i;
        last_c = !empty_c && (xfer_len_i != '0) &&
                 (pcnt_q == (xfer_len_i - LEN_BITS'(1)));
    end

    out_fifo #(
        .DEPTH  (DEPTH),
        .N_BITS (N_BITS)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .flush_i (flush_i),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .wdata_i (pe_res_i),
        .rdata_o (out_data_o),
        .count_o (count_o),
        .full_o  (full_c),
        .empty_o (empty_c)
    );

    // Transfer FSM, pop counter, done pulse and sticky overflow next-state.
    always_comb begin
        state_d    = state_q;
        pcnt_d     = pcnt_q;
        overflow_d = overflow_q | drop_c;
        done_d     = 1'b0;
        if (flush_i) begin
            state_d    = IDLE;
            pcnt_d     = '0;
            overflow_d = 1'b0;
        end else begin
            if (pop_c) pcnt_d = last_c ? '0 : pcnt_q + LEN_BITS'(1);
            done_d = pop_c && last_c;
            case (state_q)
                IDLE:       if (push_c) state_d = STREAM;
                STREAM:     if (pop_c && last_c) state_d = DRAIN_DONE;
                DRAIN_DONE: begin
                    if (pop_c && last_c)       state_d = DRAIN_DONE;
                    else if (!empty_c || push_c) state_d = STREAM;
                    else                       state_d = IDLE;
                end
                default:    state_d = IDLE;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            pcnt_q     <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pcnt_q     <= pcnt_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    assign out_valid_o = !empty_c;
    assign out_last_o  = last_c;
    assign full_o      = full_c;
    assign empty_o     = empty_c;
    assign overflow_o  = overflow_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_pe_out_buffer.sv
// Directed self-checking bench for pe_out_buffer (DEPTH=8, LEN_BITS=16).
module tb_pe_out_buffer;
    import pea_pkg::*;

    localparam int unsigned DEPTH    = 8;
    localparam int unsigned LEN_BITS = 16;

    logic                   clk_i;
    logic                   rst_n_i;
    logic [N_BITS-1:0]      pe_res_i;
    logic                   stream_valid_i;
    logic                   flush_i;
    logic [LEN_BITS-1:0]    xfer_len_i;
    logic [N_BITS-1:0]      out_data_o;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic                   out_last_o;
    logic [3:0]             count_o;
    logic                   full_o;
    logic                   empty_o;
    logic                   overflow_o;
    logic                   done_o;

    int vecs;
    int errs;

    pe_out_buffer #(.DEPTH(DEPTH), .LEN_BITS(LEN_BITS)) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .pe_res_i       (pe_res_i),
        .stream_valid_i (stream_valid_i),
        .flush_i        (flush_i),
        .xfer_len_i     (xfer_len_i),
        .out_data_o     (out_data_o),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_last_o     (out_last_o),
        .count_o        (count_o),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .overflow_o     (overflow_o),
        .done_o         (done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_flush();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0; pe_res_i = '0; stream_valid_i = 1'b0; flush_i = 1'b0;
        xfer_len_i = '0; out_ready_i = 1'b0;
        #12;
        vecs++;
        if (out_valid_o !== 1'b0 || out_last_o !== 1'b0 || done_o !== 1'b0 ||
            overflow_o !== 1'b0 || count_o !== 4'd0 || empty_o !== 1'b1 || full_o !== 1'b0) begin
            errs++;
            $display("FAIL reset: valid=%b last=%b done=%b ovf=%b cnt=%0d empty=%b full=%b (want 0 0 0 0 0 1 0)",
                     out_valid_o, out_last_o, done_o, overflow_o, count_o, empty_o, full_o);
        end
        rst_n_i = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [N_BITS-1:0] words [3];
        words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
        xfer_len_i = 16'd3; out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            stream_valid_i = 1'b1; pe_res_i = words[i];
            tick();
            vecs++;
            if (out_valid_o !== 1'b1 || out_data_o !== words[i] || out_last_o !== (i == 2) || done_o !== 1'b0) begin
                errs++;
                $display("FAIL basic_word%0d: valid=%b data=%h last=%b done=%b (want 1 %h %b 0)",
                         i, out_valid_o, out_data_o, out_last_o, done_o, words[i], (i == 2));
            end
        end
        stream_valid_i = 1'b0;
        tick();
        vecs++;
        if (done_o !== 1'b1 || empty_o !== 1'b1 || out_last_o !== 1'b0) begin
            errs++;
            $display("FAIL basic_done: done=%b empty=%b last=%b (want 1 1 0)", done_o, empty_o, out_last_o);
        end
        tick();
        vecs++;
        if (done_o !== 1'b0) begin
            errs++;
            $display("FAIL basic_done_pulse: done=%b (want 0)", done_o);
        end
    endtask

    task automatic test_overflow();
        xfer_len_i = '0; out_ready_i = 1'b0;
        for (int i = 0; i < 9; i++) begin
            stream_valid_i = 1'b1; pe_res_i = 32'(32'hA0 + i);
            tick();
            if (i == 7) begin
                vecs++;
                if (full_o !== 1'b1 || count_o !== 4'd8 || overflow_o !== 1'b0) begin
                    errs++;
                    $display("FAIL ovf_full: full=%b cnt=%0d ovf=%b (want 1 8 0)", full_o, count_o, overflow_o);
                end
            end
        end
        stream_valid_i = 1'b0;
        vecs++;
        if (overflow_o !== 1'b1 || count_o !== 4'd8) begin
            errs++;
            $display("FAIL ovf_drop: ovf=%b cnt=%0d (want 1 8)", overflow_o, count_o);
        end
        out_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            vecs++;
            if (out_valid_o !== 1'b1 || out_data_o !== 32'(32'hA0 + i)) begin
                errs++;
                $display("FAIL ovf_drain%0d: valid=%b data=%h (want 1 %h)", i, out_valid_o, out_data_o, 32'(32'hA0 + i));
            end
            tick();
        end
        out_ready_i = 1'b0;
        vecs++;
        if (empty_o !== 1'b1 || overflow_o !== 1'b1) begin
            errs++;
            $display("FAIL ovf_after_drain: empty=%b ovf=%b (want 1 1)", empty_o, overflow_o);
        end
        do_flush();
    endtask

    task automatic test_full_push_pop_and_flush();
        xfer_len_i = '0; out_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            stream_valid_i = 1'b1; pe_res_i = 32'(32'hB0 + i);
            tick();
        end
        out_ready_i = 1'b1; pe_res_i = 32'hB8;
        tick();
        out_ready_i = 1'b0; stream_valid_i = 1'b0;
        vecs++;
        if (count_o !== 4'd8 || overflow_o !== 1'b0 || full_o !== 1'b1 || out_data_o !== 32'hB1) begin
            errs++;
            $display("FAIL full_push_pop: cnt=%0d ovf=%b full=%b data=%h (want 8 0 1 b1)",
                     count_o, overflow_o, full_o, out_data_o);
        end
        stream_valid_i = 1'b1; pe_res_i = 32'hB9;
        tick();
        stream_valid_i = 1'b0; out_ready_i = 1'b1;
        tick(); tick(); tick();
        out_ready_i = 1'b0;
        vecs++;
        if (count_o !== 4'd5 || overflow_o !== 1'b1 || out_data_o !== 32'hB4) begin
            errs++;
            $display("FAIL flush_setup: cnt=%0d ovf=%b data=%h (want 5 1 b4)", count_o, overflow_o, out_data_o);
        end
        flush_i = 1'b1; stream_valid_i = 1'b1; out_ready_i = 1'b1; pe_res_i = 32'hCC;
        tick();
        flush_i = 1'b0; stream_valid_i = 1'b0; out_ready_i = 1'b0;
        vecs++;
        if (count_o !== 4'd0 || empty_o !== 1'b1 || overflow_o !== 1'b0 || done_o !== 1'b0 || out_valid_o !== 1'b0) begin
            errs++;
            $display("FAIL flush: cnt=%0d empty=%b ovf=%b done=%b valid=%b (want 0 1 0 0 0)",
                     count_o, empty_o, overflow_o, done_o, out_valid_o);
        end
    endtask

    task automatic test_unbounded();
        int sent, rcvd, bad_flags;
        sent = 0; rcvd = 0; bad_flags = 0;
        xfer_len_i = '0; out_ready_i = 1'b1;
        for (int c = 0; c < 310; c++) begin
            stream_valid_i = (sent < 300);
            pe_res_i = 32'(32'h1000 + sent);
            tick();
            if (stream_valid_i) sent++;
            if (out_last_o !== 1'b0 || done_o !== 1'b0) bad_flags++;
            if (out_valid_o === 1'b1) begin
                vecs++;
                if (out_data_o !== 32'(32'h1000 + rcvd)) begin
                    errs++;
                    $display("FAIL unbounded_word%0d: data=%h (want %h)", rcvd, out_data_o, 32'(32'h1000 + rcvd));
                end
                rcvd++;
            end
        end
        stream_valid_i = 1'b0; out_ready_i = 1'b0;
        vecs++;
        if (rcvd != 300 || bad_flags != 0) begin
            errs++;
            $display("FAIL unbounded_total: received=%0d flag_cycles=%0d (want 300 0)", rcvd, bad_flags);
        end
        do_flush();
    endtask

    task automatic test_back_to_back();
        int lasts, dones, sent;
        lasts = 0; dones = 0; sent = 0;
        xfer_len_i = 16'd2; out_ready_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            stream_valid_i = (sent < 4);
            pe_res_i = 32'(32'h50 + sent);
            tick();
            if (stream_valid_i) sent++;
            if (out_valid_o === 1'b1 && out_last_o === 1'b1) lasts++;
            if (done_o === 1'b1) dones++;
        end
        stream_valid_i = 1'b0; out_ready_i = 1'b0;
        vecs++;
        if (lasts != 2 || dones != 2 || empty_o !== 1'b1) begin
            errs++;
            $display("FAIL back_to_back: lasts=%0d dones=%0d empty=%b (want 2 2 1)", lasts, dones, empty_o);
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        dones = 0;
        xfer_len_i = 16'd8; out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            stream_valid_i = 1'b1; pe_res_i = 32'(32'h70 + i);
            tick();
        end
        stream_valid_i = 1'b0;
        vecs++;
        if (count_o !== 4'd4) begin
            errs++;
            $display("FAIL rst_mid_setup: cnt=%0d (want 4)", count_o);
        end
        #2;
        rst_n_i = 1'b0;
        #1;
        vecs++;
        if (out_valid_o !== 1'b0 || count_o !== 4'd0 || empty_o !== 1'b1 || done_o !== 1'b0 || out_last_o !== 1'b0) begin
            errs++;
            $display("FAIL rst_mid_async: valid=%b cnt=%0d empty=%b done=%b last=%b (want 0 0 1 0 0)",
                     out_valid_o, count_o, empty_o, done_o, out_last_o);
        end
        tick();
        rst_n_i = 1'b1; out_ready_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (done_o === 1'b1 || out_valid_o === 1'b1) dones++;
        end
        vecs++;
        if (dones != 0) begin
            errs++;
            $display("FAIL rst_mid_after: bad_cycles=%0d (want 0)", dones);
        end
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop_and_flush();
        test_unbounded();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/pe_out_buffer.md
PE_OUT_BUFFER -- requirements
Module: pe_out_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter LEN_BITS, default 16, width of the transfer-length and counter fields.
REQ-003 SHALL have port clk_i  input  1  single clock, rising edge.
REQ-004 SHALL have port rst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port pe_res_i  input  N_BITS  PE result word (from PE output register).
REQ-006 SHALL have port stream_valid_i  input  1  pe_res_i valid this cycle.
REQ-007 SHALL have port flush_i  input  1  synchronous clear of buffer, counters and flags.
REQ-008 SHALL have port xfer_len_i  input  LEN_BITS  words per transfer; 0 = unbounded.
REQ-009 SHALL have port out_data_o  output  N_BITS  head word.
REQ-010 SHALL have port out_valid_o  output  1  head word available.
REQ-011 SHALL have port out_ready_i  input  1  consumer accepts head word.
REQ-012 SHALL have port out_last_o  output  1  head word is final word of transfer.
REQ-013 SHALL have port count_o  output  $clog2(DEPTH)+1  occupancy.
REQ-014 SHALL have port full_o / empty_o  output  1 each  occupancy == DEPTH / == 0.
REQ-015 SHALL have port overflow_o  output  1  sticky: a valid PE word was dropped.
REQ-016 SHALL have port done_o  output  1  one-cycle pulse after last word handshake.

Function
REQ-017 Push: on a clock edge with stream_valid_i=1, pe_res_i SHALL be written at tail when !full_o, or when full_o and pop occurs the same edge.
REQ-018 Drop: stream_valid_i=1, full_o=1, no pop -> word discarded, overflow_o set next cycle, held until flush_i or reset.
REQ-019 Pop: handshake = out_valid_o && out_ready_i at rising edge; head advances.
REQ-020 First-word-fall-through: out_valid_o = !empty_o; out_data_o driven from storage head, no extra register; push-to-out_valid_o latency exactly 1 cycle.
REQ-021 out_data_o SHALL be stable while out_valid_o=1 and out_ready_i=0.
REQ-022 Pointers SHALL wrap modulo DEPTH; count_o updates +1 push only, -1 pop only, unchanged push+pop.
REQ-023 Pop counter pcnt (LEN_BITS) SHALL increment per pop; out_last_o = out_valid_o && xfer_len_i!=0 && pcnt==xfer_len_i-1.
REQ-024 Pop with out_last_o=1 SHALL reset pcnt to 0 and pulse done_o the following cycle.
REQ-025 xfer_len_i=0: out_last_o and done_o never asserted; pcnt wraps silently at 2^LEN_BITS.
REQ-026 xfer_len_i SHALL only be changed while empty_o=1 and pcnt=0; otherwise behaviour is undefined.
REQ-027 Control FSM states IDLE (pcnt=0, empty), STREAM (transfer open), DRAIN_DONE (done_o pulse): IDLE->STREAM on first push; STREAM->DRAIN_DONE on last pop; DRAIN_DONE->STREAM if non-empty, else IDLE.
REQ-028 flush_i SHALL take priority over same-cycle push and pop: pointers, count, pcnt, overflow_o cleared, FSM->IDLE, done_o not pulsed, no handshake counted.
REQ-029 Data storage SHALL not be reset; only control state is.

Reset
REQ-030 While rst_n_i=0: out_valid_o=0, out_last_o=0, done_o=0, overflow_o=0, count_o=0, empty_o=1, full_o=0, FSM=IDLE, pcnt=0; out_data_o don't-care.
REQ-031 Reset asserted mid-transfer SHALL abandon buffered words immediately without done_o.

Structure
REQ-032 N_BITS and the FSM state enum (out_buf_state_t) SHALL live in pea_pkg.
REQ-033 Storage/pointer logic SHALL be one sub-module, out_fifo (parameters DEPTH, N_BITS); FSM, counters and flags in pe_out_buffer.

Verification
REQ-034 Reset then 3 pushes (0x11,0x22,0x33), out_ready_i=1, xfer_len_i=3 -> out words 0x11,0x22,0x33, out_last_o on 0x33, done_o pulse 1 cycle later.
REQ-035 DEPTH=8, out_ready_i=0, 9 pushes -> full_o after 8th, 9th dropped, overflow_o=1, count_o=8; then drain -> first 8 words in order.
REQ-036 Full buffer, out_ready_i=1 and stream_valid_i=1 same edge -> no drop, count_o stays 8, overflow_o stays 0.
REQ-037 flush_i with count_o=5, overflow_o=1, push and pop same cycle -> next cycle count_o=0, empty_o=1, overflow_o=0, done_o=0.
REQ-038 xfer_len_i=0, 300 words streamed -> out_last_o and done_o never asserted, all 300 received in order.
REQ-039 rst_n_i pulsed low mid-transfer with 4 words buffered -> outputs at reset values asynchronously, no done_o after release.
